// File: rtl/activation_skew_feeder.sv
// -----------------------------------------------------------------------------
// activation_skew_feeder
//
// Purpose:
//   Reads one tile (SIZE rows) from the activation memory and re-times each
//   SIZE-lane row into a diagonal wavefront for the left edge of a systolic
//   array. Lane i is delayed i cycles relative to lane 0, so row k reaches
//   array row i in cycle R+2+k+i (R = first read cycle). Slots that carry no
//   real data are driven to exactly zero.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          one-cycle request to stream a tile (honoured in IDLE/DONE)
//   Rd_en          read strobe to activation memory
//   Rd_Addr        row index to activation memory
//   Activation_in  read data, valid the cycle after Rd_en, lane i at
//                  bits [DATA_WIDTH*i +: DATA_WIDTH]
//   Skew_out       skewed activations, same lane packing
//   Lane_valid     bit i high when lane i of Skew_out carries real data
//   busy           high while reading or draining
//   done           one-cycle pulse when the tile has been fully emitted
// -----------------------------------------------------------------------------
module activation_skew_feeder #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         Rd_en,
  output logic [ADDR_WIDTH-1:0]        Rd_Addr,
  input  logic [SIZE*DATA_WIDTH-1:0]   Activation_in,
  output logic [SIZE*DATA_WIDTH-1:0]   Skew_out,
  output logic [SIZE-1:0]              Lane_valid,
  output logic                         busy,
  output logic                         done
);

  // The drain counter must be able to reach SIZE itself.
  localparam int DCNT_W = $clog2(SIZE + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(SIZE - 1);
  localparam logic [DCNT_W-1:0]     LAST_DRN  = DCNT_W'(SIZE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_row;
  logic [ADDR_WIDTH-1:0] w_row_next;
  logic [DCNT_W-1:0]     r_drain;
  logic [DCNT_W-1:0]     w_drain_next;
  logic                  w_rd_en;
  logic                  r_in_vld;

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
      r_drain <= w_drain_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and strobes
  // The row counter is zero everywhere outside READ, so each tile starts its
  // addresses at 0 and never wraps. DRAIN lasts SIZE+1 cycles: the last
  // lane-(SIZE-1) datum of row SIZE-1 is presented 2*SIZE cycles after the
  // first read, which is the final DRAIN cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_row_next   = '0;
    w_drain_next = '0;
    w_rd_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_READ;
        end
      end
      ST_READ: begin
        w_rd_en = 1'b1;
        if (r_row == LAST_ROW) begin
          w_state_next = ST_DRAIN;
        end else begin
          w_row_next = r_row + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (r_drain == LAST_DRN) begin
          w_state_next = ST_DONE;
        end else begin
          w_drain_next = r_drain + DCNT_W'(1);
        end
      end
      ST_DONE: begin
        // A start in the DONE cycle chains the next tile with no gap.
        w_state_next = start ? ST_READ : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign Rd_en   = w_rd_en;
  assign Rd_Addr = w_rd_en ? r_row : '0;
  assign busy    = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign done    = (r_state == ST_DONE);

  // Memory read data arrives one cycle after the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_vld <= 1'b0;
    end else begin
      r_in_vld <= w_rd_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Skew delay lines: lane gi holds gi+1 stages (stage 0 captures the memory
  // data, stages 1..gi add the diagonal offset). Valid rides alongside the
  // data, and every data stage loads zero when its valid is low so idle slots
  // are clean at the source rather than masked at the output.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] r_dat [0:gi];
      logic [gi:0]           r_vld;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j <= gi; j++) begin
            r_dat[j] <= '0;
          end
          r_vld <= '0;
        end else begin
          r_vld[0] <= r_in_vld;
          r_dat[0] <= r_in_vld ? Activation_in[DATA_WIDTH*gi +: DATA_WIDTH] : '0;
          for (int j = 1; j <= gi; j++) begin
            r_vld[j] <= r_vld[j-1];
            r_dat[j] <= r_vld[j-1] ? r_dat[j-1] : '0;
          end
        end
      end

      assign Skew_out[DATA_WIDTH*gi +: DATA_WIDTH] = r_dat[gi];
      assign Lane_valid[gi]                        = r_vld[gi];
    end
  endgenerate

endmodule

// File: tb/tb_activation_skew_feeder.sv
module tb_activation_skew_feeder;

  localparam int SIZE = 8;
  localparam int DW   = 7;
  localparam int AW   = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic              Rd_en;
  logic [AW-1:0]     Rd_Addr;
  logic [SIZE*DW-1:0] Activation_in;
  logic [SIZE*DW-1:0] Skew_out;
  logic [SIZE-1:0]   Lane_valid;
  logic              busy;
  logic              done;

  bit zero_mode;
  int n_pass;
  int n_total;

  activation_skew_feeder #(.SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Rd_en        (Rd_en),
    .Rd_Addr      (Rd_Addr),
    .Activation_in(Activation_in),
    .Skew_out     (Skew_out),
    .Lane_valid   (Lane_valid),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: row k, lane i = 16*i+k+1, one cycle after Rd_en.
  // Non-read cycles return a nonzero junk pattern that must never leak out.
  always @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (Rd_en)
        Activation_in[DW*i +: DW] <= zero_mode ? 7'd0 : 7'(16*i + int'(Rd_Addr) + 1);
      else
        Activation_in[DW*i +: DW] <= 7'h55;
    end
  end

  typedef struct {
    int         t;
    int         lane;
    logic [6:0] data;
    logic       vld;
    logic       bz;
    logic       dn;
    logic       re;
    logic [2:0] ad;
  } spot_t;

  spot_t spot [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected outputs for a tile that started reading at relative cycle 0.
  task automatic model(input int t, input bit zm,
                       output logic [SIZE*DW-1:0] sk, output logic [SIZE-1:0] lv,
                       output logic re, output logic [AW-1:0] ad,
                       output logic bz, output logic dn);
    sk = '0;
    lv = '0;
    re = (t >= 0 && t < SIZE);
    ad = re ? AW'(t) : '0;
    bz = (t >= 0 && t <= 2*SIZE);
    dn = (t == 2*SIZE + 1);
    for (int i = 0; i < SIZE; i++) begin
      int k;
      k = t - 2 - i;
      if (k >= 0 && k < SIZE) begin
        lv[i] = 1'b1;
        sk[DW*i +: DW] = zm ? 7'd0 : 7'(16*i + k + 1);
      end
    end
  endtask

  task automatic run_tiles(input bit zm, input bit b2b, input bit spots);
    int ncyc;
    int rd_cnt;
    logic [SIZE*DW-1:0] sk_a, sk_b;
    logic [SIZE-1:0]    lv_a, lv_b;
    logic re_a, re_b, bz_a, bz_b, dn_a, dn_b;
    logic [AW-1:0] ad_a, ad_b;
    zero_mode = zm;
    ncyc   = b2b ? 40 : 22;
    rd_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      model(t, zm, sk_a, lv_a, re_a, ad_a, bz_a, dn_a);
      model(b2b ? t - 18 : -100, zm, sk_b, lv_b, re_b, ad_b, bz_b, dn_b);
      chk($sformatf("skew t=%0d", t),  64'(Skew_out),   64'(sk_a | sk_b));
      chk($sformatf("valid t=%0d", t), 64'(Lane_valid), 64'(lv_a | lv_b));
      chk($sformatf("rd_en t=%0d", t), 64'(Rd_en),      64'(re_a | re_b));
      chk($sformatf("addr t=%0d", t),  64'(Rd_Addr),    64'(ad_a | ad_b));
      chk($sformatf("busy t=%0d", t),  64'(busy),       64'(bz_a | bz_b));
      chk($sformatf("done t=%0d", t),  64'(done),       64'(dn_a | dn_b));
      if (spots) begin
        for (int e = 0; e < 12; e++) begin
          if (spot[e].t == t) begin
            chk($sformatf("spot%0d lane data", e), 64'(Skew_out[DW*spot[e].lane +: DW]), 64'(spot[e].data));
            chk($sformatf("spot%0d lane vld", e),  64'(Lane_valid[spot[e].lane]), 64'(spot[e].vld));
            chk($sformatf("spot%0d busy", e),      64'(busy),    64'(spot[e].bz));
            chk($sformatf("spot%0d done", e),      64'(done),    64'(spot[e].dn));
            chk($sformatf("spot%0d rd_en", e),     64'(Rd_en),   64'(spot[e].re));
            chk($sformatf("spot%0d addr", e),      64'(Rd_Addr), 64'(spot[e].ad));
          end
        end
      end
      if (Rd_en) rd_cnt++;
      start = (spots && (t == 5 || t == 10)) || (b2b && t == 17);
      @(negedge clk);
    end
    start = 1'b0;
    chk("rd_en count", 64'(rd_cnt), b2b ? 64'd16 : 64'd8);
  endtask

  initial begin
    //              t  lane data   vld   busy  done  rd_en addr
    spot[0]  = '{ 0, 0, 7'd0,   1'b0, 1'b1, 1'b0, 1'b1, 3'd0};
    spot[1]  = '{ 2, 0, 7'd1,   1'b1, 1'b1, 1'b0, 1'b1, 3'd2};
    spot[2]  = '{ 7, 3, 7'd51,  1'b1, 1'b1, 1'b0, 1'b1, 3'd7};
    spot[3]  = '{16, 7, 7'd120, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    spot[4]  = '{17, 7, 7'd0,   1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    spot[5]  = '{ 9, 0, 7'd8,   1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    spot[6]  = '{10, 0, 7'd0,   1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    spot[7]  = '{ 4, 3, 7'd0,   1'b0, 1'b1, 1'b0, 1'b1, 3'd4};
    spot[8]  = '{ 5, 3, 7'd49,  1'b1, 1'b1, 1'b0, 1'b1, 3'd5};
    spot[9]  = '{12, 5, 7'd86,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    spot[10] = '{ 8, 6, 7'd97,  1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    spot[11] = '{ 1, 1, 7'd0,   1'b0, 1'b1, 1'b0, 1'b1, 3'd1};

    n_pass    = 0;
    n_total   = 0;
    zero_mode = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset rd_en", 64'(Rd_en), 64'd0);
    chk("reset addr",  64'(Rd_Addr), 64'd0);
    chk("reset skew",  64'(Skew_out), 64'd0);
    chk("reset valid", 64'(Lane_valid), 64'd0);
    chk("reset busy",  64'(busy), 64'd0);
    chk("reset done",  64'(done), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of READ, at Rd_Addr=3
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset addr",  64'(Rd_Addr), 64'd3);
    chk("pre-reset valid", 64'(Lane_valid), 64'h03);
    rst = 1'b1;
    #1;
    chk("async rd_en", 64'(Rd_en), 64'd0);
    chk("async busy",  64'(busy), 64'd0);
    chk("async skew",  64'(Skew_out), 64'd0);
    chk("async valid", 64'(Lane_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("quiet rd_en c=%0d", c), 64'(Rd_en), 64'd0);
      chk($sformatf("quiet valid c=%0d", c), 64'(Lane_valid), 64'd0);
      chk($sformatf("quiet skew c=%0d", c),  64'(Skew_out), 64'd0);
      chk($sformatf("quiet busy c=%0d", c),  64'(busy | done), 64'd0);
    end

    // Single tile with table spot checks and ignored starts at R+5, R+10
    run_tiles(1'b0, 1'b0, 1'b1);
    // Back-to-back tiles, second start during DONE
    run_tiles(1'b0, 1'b1, 1'b0);
    // All-zero data: valid diagonal still present, data stays zero
    run_tiles(1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
